// File: rtl/booth_mul16_if.sv
//----------------------------------------------------------------------------
// booth_mul16_if
//----------------------------------------------------------------------------
// Handshake bundle for the sequential Booth multiplier.
//   in_valid / in_ready  : operand handshake (a, b signed 16-bit)
//   out_valid / out_ready: result handshake (product signed 32-bit)
//   busy                 : multiplier is in RUN or DONE
// Modports: master = operand producer / result consumer, slave = multiplier.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface booth_mul16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

`default_nettype wire

// File: rtl/booth_mul16.sv
//----------------------------------------------------------------------------
// booth_mul16
//----------------------------------------------------------------------------
// Sequential 16x16 signed radix-2 Booth multiplier. One Booth step per clock
// through a single AdderSubtractor16; 16 steps after acceptance the 32-bit
// product is presented on a valid/ready handshake.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : booth_mul16_if.slave (operands, product, handshakes, busy)
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

// 16-bit adder/subtractor: out = m ? a - b : a + b, f = signed overflow.
// Carry-out is not needed by the multiplier datapath and is not provided.
module AdderSubtractor16 (
  input  wire logic [15:0] a,
  input  wire logic [15:0] b,
  input  wire logic        m,
  output logic      [15:0] out,
  output logic             f
);
  logic [15:0] w_b;

  assign w_b = b ^ {16{m}};
  assign out = a + w_b + {15'd0, m};
  // Overflow: operands of equal sign producing a result of the other sign.
  assign f   = (a[15] == w_b[15]) && (out[15] != a[15]);
endmodule

module booth_mul16 (
  input  wire logic     clk,
  input  wire logic     rst_n,
  booth_mul16_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;

  logic [15:0] r_m;
  logic [15:0] r_a;
  logic [15:0] r_q;
  logic        r_q1;
  logic [4:0]  r_cnt;

  logic        w_sub;
  logic        w_sel;
  logic [15:0] w_out;
  logic        w_f;
  logic [15:0] w_s;
  logic        w_sgn;

  // Booth recoding of {Q[0], q1}: 10 -> A-M, 01 -> A+M, 00/11 -> keep A.
  assign w_sub = r_q[0] & ~r_q1;
  assign w_sel = r_q[0] ^ r_q1;

  AdderSubtractor16 u_addsub (
    .a   (r_a),
    .b   (r_m),
    .m   (w_sub),
    .out (w_out),
    .f   (w_f)
  );

  assign w_s   = w_sel ? w_out : r_a;
  // The true sign of the 17-bit step result: on overflow the 16-bit sign
  // bit is inverted. This keeps M = -32768 exact.
  assign w_sgn = w_sel ? (w_out[15] ^ w_f) : r_a[15];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)    w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd15)  w_next = S_DONE;
      S_DONE:  if (bus.out_ready)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_RUN:   bus.busy      = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready  = 1'b1;
    endcase
  end

  assign bus.product = {r_a, r_q};

  // Datapath: load on acceptance, one arithmetic right shift of
  // {sgn, S, Q} per RUN cycle, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= 16'd0;
      r_a   <= 16'd0;
      r_q   <= 16'd0;
      r_q1  <= 1'b0;
      r_cnt <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_m   <= bus.a;
            r_a   <= 16'd0;
            r_q   <= bus.b;
            r_q1  <= 1'b0;
            r_cnt <= 5'd0;
          end
        end
        S_RUN: begin
          {r_a, r_q, r_q1} <= {w_sgn, w_s, r_q};
          r_cnt            <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_booth_mul16.sv
//----------------------------------------------------------------------------
// tb_booth_mul16
//----------------------------------------------------------------------------
// Self-checking bench for booth_mul16: directed corner cases, latency,
// backpressure, mid-operation reset and a random run with output stalls.
// Expected products come from plain signed integer multiplication.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_booth_mul16;
  logic clk;
  logic rst_n;

  booth_mul16_if bus ();

  booth_mul16 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_accepted = 0;
  int          n_outputs = 0;
  logic [31:0] exp_q[$];
  bit          rand_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Reference model: signed product of sign-extended operands.
  function automatic logic [31:0] ref_mul(input logic signed [15:0] x,
                                          input logic signed [15:0] y);
    int e;
    e = int'(x) * int'(y);
    return e;
  endfunction

  // Present operands and hold until accepted; returns #1 after the
  // acceptance edge with garbage on a/b to show they are not resampled.
  task automatic issue(input logic signed [15:0] x, input logic signed [15:0] y);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = x;
    bus.b        = y;
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      fail_now("issue");
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_mul(x, y));
      n_accepted++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
    end
  endtask

  // Wait until every accepted operation has produced its output.
  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 2000) fail_now("drain");
  endtask

  // Monitor: result is taken on the edge following a sampled handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_outputs++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h, expected no output", bus.product);
      end else begin
        chk("product", bus.product, exp_q.pop_front());
      end
    end
  end

  initial begin
    int          lat;
    bit          rdy_ok;
    logic [31:0] bp_exp;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 16'd0;
    bus.b         = 16'd0;
    bus.out_ready = 1'b1;
    rand_done     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_product",   bus.product,            32'd0);
    rst_n = 1'b1;

    // 3 x 5 with latency measurement
    issue(16'sd3, 16'sd5);
    chk("accept_busy",     {31'd0, bus.busy},     32'd1);
    chk("accept_in_ready", {31'd0, bus.in_ready}, 32'd0);
    lat    = 0;
    rdy_ok = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.in_ready) rdy_ok = 1'b0;
    end
    chk("latency", lat, 32'd16);
    chk("in_ready_low_run", {31'd0, rdy_ok}, 32'd1);
    chk("product_3x5", bus.product, 32'h0000000F);
    wait_drain();

    // Directed corner values
    issue(16'sd123, -16'sd456);     wait_drain();
    issue(-16'sd1, -16'sd1);        wait_drain();
    issue(-16'sd32768, -16'sd32768); wait_drain();
    issue(-16'sd32768, 16'sd1);     wait_drain();
    issue(16'sd0, -16'sd32768);     wait_drain();
    issue(16'sd32767, -16'sd32768); wait_drain();

    // Backpressure: hold result, ignore new operands
    bus.out_ready = 1'b0;
    bp_exp = ref_mul(16'sd1234, -16'sd77);
    issue(16'sd1234, -16'sd77);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) fail_now("bp_done");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("bp_product",   bus.product,            bp_exp);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    wait_drain();

    // Reset mid-operation at iteration 7
    issue(16'sd100, 16'sd200);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("midrst_busy",      {31'd0, bus.busy},      32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_product",   bus.product,            32'd0);
    exp_q.delete();
    n_accepted--;
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'sd7, -16'sd9);
    wait_drain();

    // Random back-to-back with output stalls
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          issue(16'($urandom), 16'($urandom));
        end
        wait_drain();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("one_out_per_in", n_outputs, n_accepted);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

`default_nettype wire
